// File: rtl/cavlc_level_enc.sv
// CAVLC level encoder: reads one signed level per codeword from an external
// buffer, maps it to levelCode, and emits a right-aligned {1, suffix}
// codeword with its total length (prefix zeros implied) under a
// valid/ready handshake. Tracks suffixLength across the block.
module cavlc_level_enc #(
    parameter int LEVEL_W = 12,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4:0]         total_coeff,
    input  logic [1:0]         trailing_ones,
    input  logic [4:0]         total_levels,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [LEVEL_W-1:0] level_in,
    output logic               code_valid,
    input  logic               code_ready,
    output logic [27:0]        code_bits,
    output logic [4:0]         code_len,
    output logic               done,
    output logic               busy,
    output logic               code_err
);

    localparam int MW = LEVEL_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_EMIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  tl_q, tl_d;
    logic [4:0]  idx_q, idx_d;
    logic        t1lt3_q, t1lt3_d;
    logic [2:0]  sl_q, sl_d;
    logic [27:0] bits_q, bits_d;
    logic [4:0]  len_q, len_d;
    logic        err_q, err_d;

    logic signed [MW-1:0] lvl_x;
    logic [MW-1:0]        mag;
    logic                 lvl_pos;
    logic [31:0]          lc;
    logic [31:0]          esc;
    logic [31:0]          thr;
    logic [27:0]          enc_bits;
    logic [4:0]           enc_len;
    logic                 enc_err;
    logic [2:0]           sl_upd;

    // Escape suffix is a fixed 12-bit field; larger values clamp to all-ones.
    function automatic logic [11:0] sat_escape(input logic [31:0] v);
        return (v > 32'd4095) ? 12'd4095 : v[11:0];
    endfunction

    // Map the sampled level to levelCode, then to codeword/length and next suffixLength.
    always_comb begin
        lvl_x   = {level_in[LEVEL_W-1], level_in};
        mag     = lvl_x[MW-1] ? $unsigned(-lvl_x) : $unsigned(lvl_x);
        lvl_pos = !lvl_x[MW-1] && (mag != '0);
        enc_err = 1'b0;
        lc      = lvl_pos ? ((32'(mag) << 1) - 32'd2) : ((32'(mag) << 1) - 32'd1);

        // First non-T1 level after fewer than three trailing ones cannot be +/-1,
        // so its code space is shifted down by two.
        if ((idx_q == 5'd0) && t1lt3_q) begin
            if (mag == MW'(1)) begin
                lc      = 32'd0;
                enc_err = 1'b1;
            end else begin
                lc = lc - 32'd2;
            end
        end

        esc      = 32'd0;
        thr      = 32'd15 << sl_q;
        enc_len  = 5'd0;
        enc_bits = 28'd0;
        if (sl_q == 3'd0) begin
            if (lc < 32'd14) begin
                enc_len  = 5'(lc + 32'd1);
                enc_bits = 28'd1;
            end else if (lc < 32'd30) begin
                enc_len  = 5'd19;
                enc_bits = 28'(32'd16 + (lc - 32'd14));
            end else begin
                esc      = lc - 32'd30;
                enc_len  = 5'd28;
                enc_bits = {16'd1, sat_escape(esc)};
                enc_err  = enc_err | (esc > 32'd4095);
            end
        end else if (lc < thr) begin
            enc_len  = 5'((lc >> sl_q) + 32'd1 + 32'(sl_q));
            enc_bits = 28'((32'd1 << sl_q) | (lc & ((32'd1 << sl_q) - 32'd1)));
        end else begin
            esc      = lc - thr;
            enc_len  = 5'd28;
            enc_bits = {16'd1, sat_escape(esc)};
            enc_err  = enc_err | (esc > 32'd4095);
        end

        // suffixLength adapts upward: first leave zero, then grow on large magnitudes.
        sl_upd = (sl_q == 3'd0) ? 3'd1 : sl_q;
        if ((32'(mag) > (32'd3 << (sl_upd - 3'd1))) && (sl_upd < 3'd6)) begin
            sl_upd = sl_upd + 3'd1;
        end
    end

    // State register; reset abandons any pending codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one RD/CAP/EMIT round per level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (total_levels == 5'd0) ? S_DONE : S_RD;
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = S_EMIT;
            S_EMIT: if (code_ready) state_d = (5'(idx_q + 5'd1) == tl_q) ? S_DONE : S_RD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        rd_en      = (state_q == S_RD);
        rd_addr    = rd_en ? ADDR_W'(idx_q) : '0;
        code_valid = (state_q == S_EMIT);
        done       = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
    end

    // Block context and codeword next-state values.
    always_comb begin
        tl_d    = tl_q;
        idx_d   = idx_q;
        t1lt3_d = t1lt3_q;
        sl_d    = sl_q;
        bits_d  = bits_q;
        len_d   = len_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tl_d    = total_levels;
                    idx_d   = 5'd0;
                    t1lt3_d = (trailing_ones != 2'd3);
                    sl_d    = ((total_coeff > 5'd10) && (trailing_ones != 2'd3)) ? 3'd1 : 3'd0;
                    err_d   = 1'b0;
                end
            end
            S_CAP: begin
                bits_d = enc_bits;
                len_d  = enc_len;
                sl_d   = sl_upd;
                err_d  = err_q | enc_err;
            end
            S_EMIT: begin
                if (code_ready) idx_d = idx_q + 5'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers, all cleared by reset so no stale codeword survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl_q    <= 5'd0;
            idx_q   <= 5'd0;
            t1lt3_q <= 1'b0;
            sl_q    <= 3'd0;
            bits_q  <= 28'd0;
            len_q   <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            tl_q    <= tl_d;
            idx_q   <= idx_d;
            t1lt3_q <= t1lt3_d;
            sl_q    <= sl_d;
            bits_q  <= bits_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign code_bits = bits_q;
    assign code_len  = len_q;
    assign code_err  = err_q;

endmodule

// File: tb/tb_cavlc_level_enc.sv
// Bench for cavlc_level_enc: block table plus per-level codeword table,
// expected codewords queued at stimulus time and popped on handshake.
module tb_cavlc_level_enc;

    localparam int LW = 12;
    localparam int AW = 4;
    localparam int NB = 10;
    localparam int NL = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [4:0]    total_coeff;
    logic [1:0]    trailing_ones;
    logic [4:0]    total_levels;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] level_in;
    logic          code_valid;
    logic          code_ready;
    logic [27:0]   code_bits;
    logic [4:0]    code_len;
    logic          done;
    logic          busy;
    logic          code_err;

    cavlc_level_enc #(.LEVEL_W(LW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .total_coeff  (total_coeff),
        .trailing_ones(trailing_ones),
        .total_levels (total_levels),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .level_in     (level_in),
        .code_valid   (code_valid),
        .code_ready   (code_ready),
        .code_bits    (code_bits),
        .code_len     (code_len),
        .done         (done),
        .busy         (busy),
        .code_err     (code_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { int tc; int t1; int tl; int err; } blk_t;
    typedef struct packed { int blk; int level; int len; int bits; } lvl_t;
    typedef struct packed { logic [4:0] len; logic [27:0] bits; } exp_t;

    blk_t blks [NB];
    lvl_t lvls [NL];
    exp_t exp_q [$];
    logic [LW-1:0] mem [16];

    int n_vec = 0;
    int n_bad = 0;
    int rd_seen = 0;

    // Level buffer: data appears the cycle after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_in <= '0;
        else if (rd_en) level_in <= mem[rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Inspect the cycle about to end: read addresses and accepted codewords.
    task automatic observe();
        exp_t e;
        if (rd_en) begin
            chk("rd_addr", 32'(rd_addr), 32'(rd_seen));
            rd_seen++;
        end
        if (code_valid && code_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_code: got len %0d bits 0x%0h, want no codeword", code_len, code_bits);
            end else begin
                e = exp_q.pop_front();
                chk("code_len", 32'(code_len), 32'(e.len));
                chk("code_bits", 32'(code_bits), 32'(e.bits));
            end
        end
    endtask

    task automatic tick();
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 12 && !code_valid; i++) tick();
        chk("valid_seen", 32'(code_valid), 32'd1);
    endtask

    task automatic run_blk(input int b);
        int   k;
        int   cyc;
        int   got;
        exp_t e;
        k = 0;
        rd_seen = 0;
        for (int i = 0; i < NL; i++) begin
            if (lvls[i].blk == b) begin
                mem[k] = 12'(lvls[i].level);
                e.len  = 5'(lvls[i].len);
                e.bits = 28'(lvls[i].bits);
                exp_q.push_back(e);
                k++;
            end
        end
        total_coeff   = 5'(blks[b].tc);
        trailing_ones = 2'(blks[b].t1);
        total_levels  = 5'(blks[b].tl);
        code_ready    = 1'b1;
        start         = 1'b1;
        cyc = 0;
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            tick();
            start = 1'b0;
            cyc++;
            if (cyc == 1) begin
                chk("err_clear", 32'(code_err), 32'd0);
                chk("busy_run", 32'(busy), 32'd1);
            end
            if (done) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", 32'(cyc), 32'(3 * blks[b].tl + 1));
        chk("err_final", 32'(code_err), 32'(blks[b].err));
        chk("rd_count", 32'(rd_seen), 32'(blks[b].tl));
        chk("codes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   got;

        blks[0] = '{5, 3, 1, 0};
        blks[1] = '{4, 3, 2, 0};
        blks[2] = '{11, 0, 1, 0};
        blks[3] = '{3, 2, 1, 1};
        blks[4] = '{5, 3, 1, 0};
        blks[5] = '{8, 3, 4, 0};
        blks[6] = '{6, 1, 2, 0};
        blks[7] = '{16, 0, 7, 0};
        blks[8] = '{5, 3, 1, 0};
        blks[9] = '{3, 3, 0, 0};

        lvls[0]  = '{0, 1, 1, 'h1};
        lvls[1]  = '{1, 8, 19, 'h10};
        lvls[2]  = '{1, 1, 3, 'h4};
        lvls[3]  = '{2, -3, 3, 'h3};
        lvls[4]  = '{3, 1, 1, 'h1};
        lvls[5]  = '{4, 16, 28, 'h1000};
        lvls[6]  = '{5, -7, 14, 'h1};
        lvls[7]  = '{5, 20, 12, 'h6};
        lvls[8]  = '{5, -100, 28, 'h104F};
        lvls[9]  = '{5, 1, 5, 'h10};
        lvls[10] = '{6, 2, 1, 'h1};
        lvls[11] = '{6, -2, 3, 'h3};
        lvls[12] = '{7, -2048, 28, 'h1FDF};
        lvls[13] = '{7, 2047, 28, 'h1FC0};
        lvls[14] = '{7, -1000, 28, 'h1757};
        lvls[15] = '{7, 500, 28, 'h12F6};
        lvls[16] = '{7, 300, 28, 'h1076};
        lvls[17] = '{7, 400, 19, 'h5E};
        lvls[18] = '{7, 400, 19, 'h5E};
        lvls[19] = '{8, -15, 19, 'h1F};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst_n = 1'b0;
        start = 1'b0;
        code_ready = 1'b1;
        total_coeff = '0;
        trailing_ones = '0;
        total_levels = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(code_err), 32'd0);
        chk("rst_len", 32'(code_len), 32'd0);
        chk("rst_bits", 32'(code_bits), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int b = 0; b < NB; b++) run_blk(b);

        // Backpressure for three cycles, with an ignored start during EMIT.
        rd_seen = 0;
        mem[0] = 12'd8;
        e.len = 5'd19;
        e.bits = 28'h10;
        exp_q.push_back(e);
        code_ready = 1'b0;
        total_coeff = 5'd4;
        trailing_ones = 2'd3;
        total_levels = 5'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid();
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", 32'(code_valid), 32'd1);
            chk("hold_len", 32'(code_len), 32'd19);
            chk("hold_bits", 32'(code_bits), 32'h10);
            chk("hold_rd_en", 32'(rd_en), 32'd0);
            if (k == 0) begin
                start = 1'b1;
                total_coeff = 5'd16;
                trailing_ones = 2'd0;
                total_levels = 5'd5;
            end
            tick();
            start = 1'b0;
        end
        code_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12 && got == 0; i++) begin
            tick();
            if (done) got = 1;
        end
        chk("bp_done", 32'(got), 32'd1);
        chk("bp_rd_count", 32'(rd_seen), 32'd1);
        chk("bp_codes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset while a codeword is pending; it must never reappear.
        rd_seen = 0;
        mem[0] = 12'd1;
        mem[1] = 12'd5;
        code_ready = 1'b0;
        total_coeff = 5'd3;
        trailing_ones = 2'd2;
        total_levels = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid();
        chk("pend_err", 32'(code_err), 32'd1);
        chk("pend_len", 32'(code_len), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(code_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(code_err), 32'd0);
        chk("mid_rst_bits", 32'(code_bits), 32'd0);
        chk("mid_rst_len", 32'(code_len), 32'd0);
        chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
        chk("mid_rst_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        code_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_replay", 32'(code_valid), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        run_blk(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cavlc_level_enc.md
CAVLC_LEVEL_ENC -- requirements
Module: cavlc_level_enc

Interface
REQ-001 SHALL have parameter LEVEL_W, default 12, giving the signed level sample width.
REQ-002 SHALL have parameter ADDR_W, default 4, giving the level buffer read-address width.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a block; honoured only in IDLE.
REQ-006 SHALL have port total_coeff, input, 5 bits: TotalCoeff of the block (0..16), sampled on start.
REQ-007 SHALL have port trailing_ones, input, 2 bits: TrailingOnes (0..3), sampled on start.
REQ-008 SHALL have port total_levels, input, 5 bits: non-T1 level count (0..16), sampled on start.
REQ-009 SHALL have port rd_en, output, 1 bit: level buffer read strobe.
REQ-010 SHALL have port rd_addr, output, ADDR_W bits: level buffer read index.
REQ-011 SHALL have port level_in, input, LEVEL_W bits: signed level, valid the cycle after rd_en.
REQ-012 SHALL have port code_valid, output, 1 bit: codeword available.
REQ-013 SHALL have port code_ready, input, 1 bit: downstream bit packer accepts the codeword.
REQ-014 SHALL have port code_bits, output, 28 bits: right-aligned codeword {1'b1, suffix}; leading prefix zeros are implied by code_len.
REQ-015 SHALL have port code_len, output, 5 bits: total codeword length, 1..28.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at block end.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port code_err, output, 1 bit: sticky error flag, cleared on accepted start.

Function
REQ-019 SHALL implement FSM states IDLE, RD, CAP, EMIT, DONE.
REQ-020 IDLE with start SHALL latch the block inputs, set idx=0 and clear code_err; total_levels=0 goes to DONE, otherwise to RD.
REQ-021 RD SHALL assert rd_en=1 with rd_addr=idx for exactly one cycle, then go to CAP.
REQ-022 CAP SHALL sample level_in and register code_bits, code_len and the next suffixLength, then go to EMIT.
REQ-023 EMIT SHALL hold code_valid=1 and code_bits/code_len stable until code_valid&&code_ready.
REQ-024 On acceptance, idx SHALL increment; if idx+1==total_levels go to DONE, else go to RD.
REQ-025 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 Throughput SHALL be one codeword per 3 cycles when code_ready is held high.
REQ-028 suffixLength init SHALL be 1 if total_coeff>10 and trailing_ones<3, else 0.
REQ-029 levelCode SHALL be 2*level-2 for level>0, else -2*level-1; computed at 13 bits unsigned.
REQ-030 For idx=0 with trailing_ones<3, levelCode SHALL be reduced by 2.
REQ-031 For idx=0 with trailing_ones<3, |level|==1 is illegal and SHALL set code_err, encoded with levelCode=0.
REQ-032 Encoding with sL=0 SHALL be:
  - levelCode<14: len=levelCode+1, bits=1.
  - 14<=levelCode<30: len=19, bits=16+(levelCode-14).
  - otherwise: len=28, bits=4096+(levelCode-30).
REQ-033 Encoding with sL>0 SHALL be:
  - levelCode<(15<<sL): len=(levelCode>>sL)+1+sL, bits=(1<<sL)|(levelCode mod 2^sL).
  - otherwise: len=28, bits=4096+(levelCode-(15<<sL)).
REQ-034 An escape suffix >4095 SHALL saturate to 4095 and set code_err.
REQ-035 suffixLength update after each level SHALL be, in order:
  - if sL==0 then sL=1;
  - then, if |level|>(3<<(sL-1)) and sL<6, sL=sL+1.

Reset
REQ-036 rst_n low SHALL force IDLE asynchronously from any state, including mid-EMIT.
REQ-037 Under reset: rd_en, code_valid, done, busy and code_err SHALL be 0; code_bits, code_len, rd_addr, idx and sL SHALL be 0.
REQ-038 A codeword pending at reset SHALL be discarded and never presented again.

Verification
REQ-039 Scenario: tc=5, T1=3, levels{+1}, ready=1 -> rd_addr 0; code len=1 bits=1; done pulse; total 4 cycles start-to-done.
REQ-040 Scenario: tc=4, T1=3, levels{+8,+1} -> first code len=19 bits=0x10 (sL becomes 2); second code len=3 bits=0x4.
REQ-041 Scenario: tc=11, T1=0, levels{-3} -> sL init 1, levelCode=3; code len=3 bits=3; sL stays 1.
REQ-042 Scenario: tc=3, T1=2, levels{+1} -> code_err=1 and code len=1 bits=1 emitted; code_err clears on next start.
REQ-043 Scenario: code_ready low 3 cycles during EMIT -> code_valid, code_bits and code_len stable; rd_en stays 0.
REQ-044 Scenarios:
  - total_levels=0 -> done the cycle after start; rd_en never asserted.
  - rst_n low mid-EMIT -> all outputs 0 and state IDLE; a following start runs normally.
